// File: rtl/fwd_sel_gen.sv
// -----------------------------------------------------------------------------
// fwd_sel_gen
//
// Forwarding-select generator for a 6-stage pipe (IF, ID, EX, MEM, MEM2, WB).
// A small shadow pipe records {rd, we, ld} for every instruction that is in
// EX, MEM, MEM2 or WB. While an instruction sits in ID, each of its source
// operands is compared against that shadow pipe to decide where the operand
// will come from once the instruction reaches EX. The result is registered
// so it drives the EX operand muxes directly. A combinational load-use stall
// is raised when a source depends on a load that is still in EX.
//
// Select encoding (fixed by the EX mux):
//   000 regfile            011 MEM ALU result     010 MEM2 ALU result
//   001 WB result          110 MEM2 load data     101 regfile write-through
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous, active-high reset
//   id_valid        in   ID holds a real instruction
//   id_rs1, id_rs2  in   ID source register addresses
//   id_use_rs1/2    in   source is actually read by the instruction
//   id_rd           in   ID destination register
//   id_reg_we       in   ID instruction writes rd
//   id_is_load      in   ID instruction is a load (data ready end of MEM2)
//   pipe_stall      in   global freeze: nothing advances
//   flush           in   branch redirect: kill ID and EX contents
//   fwd_sel_a/b     out  registered EX operand select for rs1/rs2
//   load_use_stall  out  hold IF/ID and insert an EX bubble (combinational)
// -----------------------------------------------------------------------------
module fwd_sel_gen #(
  parameter int unsigned REG_AW   = 5,
  parameter bit          ZERO_FWD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_we,
  input  logic              id_is_load,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic [2:0]        fwd_sel_a,
  output logic [2:0]        fwd_sel_b,
  output logic              load_use_stall
);

  localparam logic [2:0] SEL_RF       = 3'b000;
  localparam logic [2:0] SEL_MEM_ALU  = 3'b011;
  localparam logic [2:0] SEL_MEM2_ALU = 3'b010;
  localparam logic [2:0] SEL_WB       = 3'b001;
  localparam logic [2:0] SEL_MEM2_LD  = 3'b110;
  localparam logic [2:0] SEL_WR_THRU  = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } ent_t;

  // Shadow pipe: one entry per downstream stage.
  ent_t ex_q, mem_q, mem2_q, wb_q;
  ent_t ex_next;

  // {stall_request, sel} per operand.
  logic [3:0] res_a, res_b;

  // An entry supplies rs when it writes that register; x0 is hardwired to
  // zero, so it is only ever forwarded in the debug configuration.
  function automatic logic hits(input ent_t e, input logic [REG_AW-1:0] rs);
    return e.we && (e.rd == rs) && (ZERO_FWD || (rs != '0));
  endfunction

  // Entries are examined youngest first, so the most recent writer of a
  // register always wins. The select names where the value will be when the
  // consumer reaches EX, i.e. one stage further on than the entry is now.
  function automatic logic [3:0] resolve(input logic              en,
                                         input logic [REG_AW-1:0] rs,
                                         input ent_t              ex,
                                         input ent_t              mem,
                                         input ent_t              mem2,
                                         input ent_t              wb);
    logic [3:0] r;
    r = {1'b0, SEL_RF};
    if (en) begin
      if (hits(ex, rs)) begin
        // Load in EX: data not available in time, ask for one bubble.
        r = ex.ld ? {1'b1, SEL_RF} : {1'b0, SEL_MEM_ALU};
      end else if (hits(mem, rs)) begin
        r = {1'b0, (mem.ld ? SEL_MEM2_LD : SEL_MEM2_ALU)};
      end else if (hits(mem2, rs)) begin
        r = {1'b0, SEL_WB};
      end else if (hits(wb, rs)) begin
        r = {1'b0, SEL_WR_THRU};
      end
    end
    return r;
  endfunction

  assign res_a = resolve(id_valid & id_use_rs1, id_rs1, ex_q, mem_q, mem2_q, wb_q);
  assign res_b = resolve(id_valid & id_use_rs2, id_rs2, ex_q, mem_q, mem2_q, wb_q);

  // Flush discards the ID instruction, so a stall on its behalf is moot.
  assign load_use_stall = ~rst & ~flush & (res_a[3] | res_b[3]);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    ex_next = '0;
    if (id_valid && !flush && !load_use_stall) begin
      ex_next = '{rd: id_rd, we: id_reg_we, ld: id_is_load};
    end
  end

  // NOTE: the shadow pipe is only four small entries, so every bit is reset;
  // a bubble (we=0) must never be mistaken for a writer after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      mem2_q    <= '0;
      wb_q      <= '0;
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
    end else if (!pipe_stall) begin
      // NOTE: non-blocking assignments let the shift read every entry's old
      // value regardless of statement order.
      wb_q   <= mem2_q;
      mem2_q <= mem_q;
      mem_q  <= ex_q;
      ex_q   <= ex_next;
      if (flush || load_use_stall) begin
        fwd_sel_a <= SEL_RF;
        fwd_sel_b <= SEL_RF;
      end else begin
        fwd_sel_a <= res_a[2:0];
        fwd_sel_b <= res_b[2:0];
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_gen.sv
// -----------------------------------------------------------------------------
// tb_fwd_sel_gen
//
// Bench for fwd_sel_gen. A directed vector table walks through the forwarding
// distances, load-use, priority, x0, freeze and flush cases; a hand-written
// sequence exercises asynchronous reset in mid-cycle; then randomized traffic
// is compared against a reference model that keeps the issued instruction
// history in a queue and derives the select from the producer's distance.
// -----------------------------------------------------------------------------
module tb_fwd_sel_gen;

  localparam int AW = 5;

  // Select codes, as the EX mux defines them.
  localparam int S_RF   = 0;  // 000
  localparam int S_WB   = 1;  // 001
  localparam int S_M2A  = 2;  // 010
  localparam int S_MA   = 3;  // 011
  localparam int S_WT   = 5;  // 101
  localparam int S_LD   = 6;  // 110

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          id_reg_we, id_is_load;
  logic          pipe_stall, flush;
  logic [2:0]    fwd_sel_a, fwd_sel_b;
  logic          load_use_stall;

  always #5 clk = ~clk;

  fwd_sel_gen #(.REG_AW(AW), .ZERO_FWD(1'b0)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_rd          (id_rd),
    .id_reg_we      (id_reg_we),
    .id_is_load     (id_is_load),
    .pipe_stall     (pipe_stall),
    .flush          (flush),
    .fwd_sel_a      (fwd_sel_a),
    .fwd_sel_b      (fwd_sel_b),
    .load_use_stall (load_use_stall)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0b required=%0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus record
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
    logic          ps;
    logic          fl;
    logic          exp_stall;  // combinational stall during this cycle
    logic [2:0]    exp_a;      // sel registered at the end of this cycle
    logic [2:0]    exp_b;
  } vec_t;

  function automatic vec_t mk(input int v, input int r1, input int r2, input int u1,
                              input int u2, input int rd, input int we, input int ld,
                              input int ps, input int fl, input int es, input int ea,
                              input int eb);
    vec_t x;
    x.valid     = 1'(v);
    x.rs1       = AW'(r1);
    x.rs2       = AW'(r2);
    x.u1        = 1'(u1);
    x.u2        = 1'(u2);
    x.rd        = AW'(rd);
    x.we        = 1'(we);
    x.ld        = 1'(ld);
    x.ps        = 1'(ps);
    x.fl        = 1'(fl);
    x.exp_stall = 1'(es);
    x.exp_a     = 3'(ea);
    x.exp_b     = 3'(eb);
    return x;
  endfunction

  task automatic apply(input vec_t x);
    id_valid   = x.valid;
    id_rs1     = x.rs1;
    id_rs2     = x.rs2;
    id_use_rs1 = x.u1;
    id_use_rs2 = x.u2;
    id_rd      = x.rd;
    id_reg_we  = x.we;
    id_is_load = x.ld;
    pipe_stall = x.ps;
    flush      = x.fl;
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: queue of issued slots, index 0 = most recently issued.
  // A producer at distance d (0 = issued last cycle) supplies the consumer
  // through: d0 ALU -> 011 (load -> stall), d1 -> 010 (load -> 110),
  // d2 -> 001, d3 -> 101, older -> regfile.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AW-1:0] rd;
    logic          we;
    logic          ld;
  } m_ent_t;

  m_ent_t     hist[$];
  logic       r_stall;
  logic [2:0] r_a, r_b;
  logic [2:0] e_a, e_b;

  function automatic logic [3:0] m_operand(input logic en, input logic [AW-1:0] rs);
    if (!id_valid || !en || rs == '0) return 4'b0000;
    for (int d = 0; d < hist.size(); d++) begin
      if (hist[d].we && hist[d].rd == rs) begin
        case (d)
          0:       return hist[d].ld ? 4'b1000 : 4'b0011;
          1:       return hist[d].ld ? 4'b0110 : 4'b0010;
          2:       return 4'b0001;
          default: return 4'b0101;
        endcase
      end
    end
    return 4'b0000;
  endfunction

  task automatic model_reset();
    hist.delete();
    e_a = 3'b000;
    e_b = 3'b000;
  endtask

  task automatic model_eval();
    logic [3:0] ra, rb;
    ra      = m_operand(id_use_rs1, id_rs1);
    rb      = m_operand(id_use_rs2, id_rs2);
    r_stall = !rst && !flush && (ra[3] || rb[3]);
    r_a     = ra[2:0];
    r_b     = rb[2:0];
  endtask

  task automatic model_commit();
    m_ent_t n;
    if (rst) begin
      model_reset();
    end else if (!pipe_stall) begin
      n = '0;
      if (id_valid && !flush && !r_stall) n = '{rd: id_rd, we: id_reg_we, ld: id_is_load};
      hist.push_front(n);
      if (hist.size() > 4) void'(hist.pop_back());
      e_a = (flush || r_stall) ? 3'b000 : r_a;
      e_b = (flush || r_stall) ? 3'b000 : r_b;
    end
  endtask

  // Inputs are applied just after a rising edge; the stall is sampled on the
  // falling edge, registered outputs 1 time unit after the next rising edge.
  task automatic do_cycle(output logic st_seen);
    @(negedge clk);
    st_seen = load_use_stall;
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  vec_t vecs[28];

  initial begin
    logic st;
    vec_t rv;

    rst        = 1'b1;
    id_valid   = 1'b0;
    id_rs1     = '0;
    id_rs2     = '0;
    id_use_rs1 = 1'b0;
    id_use_rs2 = 1'b0;
    id_rd      = '0;
    id_reg_we  = 1'b0;
    id_is_load = 1'b0;
    pipe_stall = 1'b0;
    flush      = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("reset_sel_a", 32'(fwd_sel_a), 0);
    check("reset_sel_b", 32'(fwd_sel_b), 0);
    check("reset_stall", 32'(load_use_stall), 0);
    rst = 1'b0;

    //             v  rs1 rs2 u1 u2 rd we ld ps fl  st  sel_a  sel_b
    // ALU chain: add x5 ; add x6,x5,x5
    vecs[0]  = mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[1]  = mk(1,  5,  5, 1, 1,  6, 1, 0, 0, 0, 0, S_MA,  S_MA);
    // Distance: producer x7, then consumers at distance 2, 3, 4, 5
    vecs[2]  = mk(1,  0,  0, 0, 0,  7, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[3]  = mk(1, 11,  0, 1, 0, 10, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[4]  = mk(1,  7,  1, 1, 1,  0, 0, 0, 0, 0, 0, S_M2A, S_RF);
    vecs[5]  = mk(1,  7,  6, 1, 1,  0, 0, 0, 0, 0, 0, S_WB,  S_WT);
    vecs[6]  = mk(1,  7,  0, 1, 0,  0, 0, 0, 0, 0, 0, S_WT,  S_RF);
    vecs[7]  = mk(1,  7,  0, 1, 0,  0, 0, 0, 0, 0, 0, S_RF,  S_RF);
    // Load-use: lw x8 ; add x9,x8,x0 (held one cycle by the stall)
    vecs[8]  = mk(1,  2,  0, 1, 0,  8, 1, 1, 0, 0, 0, S_RF,  S_RF);
    vecs[9]  = mk(1,  8,  0, 1, 1,  9, 1, 0, 0, 0, 1, S_RF,  S_RF);
    vecs[10] = mk(1,  8,  0, 1, 1,  9, 1, 0, 0, 0, 0, S_LD,  S_RF);
    // Priority: x3 written at distances 0 and 2 -> youngest wins
    vecs[11] = mk(1,  0,  0, 0, 0,  3, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[12] = mk(1,  0,  0, 0, 0, 12, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[13] = mk(1,  0,  0, 0, 0,  3, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[14] = mk(1,  3,  3, 1, 1,  0, 0, 0, 0, 0, 0, S_MA,  S_MA);
    // x0 is never forwarded
    vecs[15] = mk(1,  0,  0, 0, 0,  0, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[16] = mk(1,  0,  0, 1, 1,  0, 0, 0, 0, 0, 0, S_RF,  S_RF);
    // Freeze 3 cycles (flush inside the freeze is ignored), then resume
    vecs[17] = mk(1,  0,  0, 0, 0, 20, 1, 0, 0, 0, 0, S_RF,  S_RF);
    vecs[18] = mk(1, 20, 20, 1, 1,  0, 0, 0, 0, 0, 0, S_MA,  S_MA);
    vecs[19] = mk(1, 20,  0, 1, 0, 21, 0, 0, 1, 0, 0, S_MA,  S_MA);
    vecs[20] = mk(1, 20,  0, 1, 0, 21, 0, 0, 1, 1, 0, S_MA,  S_MA);
    vecs[21] = mk(1, 20,  0, 1, 0, 21, 0, 0, 1, 0, 0, S_MA,  S_MA);
    vecs[22] = mk(1, 20,  0, 1, 0, 21, 0, 0, 0, 0, 0, S_M2A, S_RF);
    // Flush over a pending load-use; the killed x26 writer must not forward
    vecs[23] = mk(1,  0,  0, 0, 0, 25, 1, 1, 0, 0, 0, S_RF,  S_RF);
    vecs[24] = mk(1, 25,  0, 1, 0, 26, 1, 0, 0, 1, 0, S_RF,  S_RF);
    vecs[25] = mk(1, 25,  0, 1, 0,  0, 0, 0, 0, 0, 0, S_LD,  S_RF);
    vecs[26] = mk(1, 26, 25, 1, 1,  0, 0, 0, 0, 0, 0, S_RF,  S_WB);
    // Invalid ID slot: no forwarding even though x25 is still in WB
    vecs[27] = mk(0, 25,  0, 1, 0,  0, 0, 0, 0, 0, 0, S_RF,  S_RF);

    for (int i = 0; i < 28; i++) begin
      apply(vecs[i]);
      do_cycle(st);
      check($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
      check($sformatf("vec%0d_sel_a", i), 32'(fwd_sel_a), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d_sel_b", i), 32'(fwd_sel_b), 32'(vecs[i].exp_b));
    end

    // Asynchronous reset between edges while a load-use stall is pending.
    apply(mk(1,  0,  0, 0, 0, 29, 1, 0, 0, 0, 0, 0, 0));
    do_cycle(st);
    apply(mk(1, 29,  0, 1, 0, 30, 1, 1, 0, 0, 0, 0, 0));
    do_cycle(st);
    check("rst_pre_sel_a", 32'(fwd_sel_a), S_MA);
    apply(mk(1, 30, 29, 1, 1, 31, 1, 0, 0, 0, 0, 0, 0));
    #1;
    check("rst_pre_stall", 32'(load_use_stall), 1);
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_async_sel_a", 32'(fwd_sel_a), 0);
    check("rst_async_sel_b", 32'(fwd_sel_b), 0);
    check("rst_async_stall", 32'(load_use_stall), 0);
    rst = 1'b0;
    do_cycle(st);
    check("rst_post_stall", 32'(st), 0);
    check("rst_post_sel_a", 32'(fwd_sel_a), 0);
    check("rst_post_sel_b", 32'(fwd_sel_b), 0);

    // Randomized traffic on a narrow register range to provoke many hits.
    for (int n = 0; n < 3000; n++) begin
      rv       = '0;
      rv.valid = ($urandom_range(0, 99) < 85);
      rv.rs1   = AW'($urandom_range(0, 7));
      rv.rs2   = AW'($urandom_range(0, 7));
      rv.u1    = ($urandom_range(0, 3) != 0);
      rv.u2    = ($urandom_range(0, 3) != 0);
      rv.rd    = AW'($urandom_range(0, 7));
      rv.we    = ($urandom_range(0, 9) < 8);
      rv.ld    = ($urandom_range(0, 9) < 3);
      rv.ps    = ($urandom_range(0, 9) == 0);
      rv.fl    = ($urandom_range(0, 11) == 0);
      apply(rv);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      do_cycle(st);
      check("rnd_stall", 32'(st), 32'(r_stall));
      check("rnd_sel_a", 32'(fwd_sel_a), 32'(e_a));
      check("rnd_sel_b", 32'(fwd_sel_b), 32'(e_b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
